// File: rtl/power_state_ctrl.sv
// -----------------------------------------------------------------------------
// power_state_ctrl
//   Power on/off state machine for the car, driven by the single power button.
//   A hold of ON_HOLD consecutive pressed cycles turns the car ON; a hold of
//   OFF_HOLD consecutive pressed cycles while ON turns it OFF. After every
//   toggle the button must be released before another press is counted.
//   This block is the single source of power_on for all power-gated logic.
//
// Optional feature (compile-time macro AUTO_OFF_EN):
//   When defined, the car switches itself OFF after IDLE_TIMEOUT consecutive
//   ON cycles with no activity and no button press. When undefined, the idle
//   logic is absent and the car leaves ON only by long press or reset.
//
// Ports
//   clk        in   1  system clock
//   rst_n      in   1  asynchronous active-low reset
//   power_btn  in   1  synchronised button level, 1 = pressed
//   activity   in   1  drive/turn command this cycle (auto-off only)
//   power_on   out  1  car powered (registered)
//   on_pulse   out  1  strobe in the first cycle power_on is 1
//   off_pulse  out  1  strobe in the first cycle power_on is 0 after ON
//   state      out  2  FSM state: 00 OFF, 01 ON, 10 WAIT_REL
// -----------------------------------------------------------------------------
module power_state_ctrl #(
   parameter int ON_HOLD      = 50,
   parameter int OFF_HOLD     = 100,
   parameter int IDLE_TIMEOUT = 1000,
   parameter int CW           = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       power_btn,
   input  logic       activity,
   output logic       power_on,
   output logic       on_pulse,
   output logic       off_pulse,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ST_OFF      = 2'b00,
      ST_ON       = 2'b01,
      ST_WAIT_REL = 2'b10
   } state_t;

   // Counter values seen on the edge that samples the final required cycle.
   localparam logic [CW-1:0] ON_MAX  = CW'(ON_HOLD - 1);
   localparam logic [CW-1:0] OFF_MAX = CW'(OFF_HOLD - 1);

   // Saturating increment so a very long hold never wraps back to zero.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      if (v == {CW{1'b1}}) begin
         sat_inc = v;
      end else begin
         sat_inc = v + {{(CW-1){1'b0}}, 1'b1};
      end
   endfunction

   state_t        state_r;
   logic [CW-1:0] hold_cnt_r;
   logic          power_on_r;
   logic          on_pulse_r;
   logic          off_pulse_r;
   logic          timeout_s;

`ifdef AUTO_OFF_EN
   localparam logic [CW-1:0] IDLE_MAX = CW'(IDLE_TIMEOUT - 1);

   logic [CW-1:0] idle_cnt_r;
   logic          idle_s;

   assign idle_s    = ~activity & ~power_btn;
   assign timeout_s = (state_r == ST_ON) && idle_s && (idle_cnt_r == IDLE_MAX);

   // Idle counter: counts only while ON and idle; any activity, press,
   // timeout or departure from ON clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt_r <= '0;
      end else if ((state_r == ST_ON) && idle_s && !timeout_s) begin
         idle_cnt_r <= sat_inc(idle_cnt_r);
      end else begin
         idle_cnt_r <= '0;
      end
   end
`else
   assign timeout_s = 1'b0;

   // activity and IDLE_TIMEOUT only matter with auto-off; tie them off here.
   logic unused_s;
   assign unused_s = &{1'b0, activity, (IDLE_TIMEOUT > 0)};
`endif

   // Main FSM with registered outputs; pulses default low every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_OFF;
         hold_cnt_r  <= '0;
         power_on_r  <= 1'b0;
         on_pulse_r  <= 1'b0;
         off_pulse_r <= 1'b0;
      end else begin
         on_pulse_r  <= 1'b0;
         off_pulse_r <= 1'b0;
         case (state_r)
            ST_OFF: begin
               if (power_btn && (hold_cnt_r == ON_MAX)) begin
                  power_on_r <= 1'b1;
                  on_pulse_r <= 1'b1;
                  state_r    <= ST_WAIT_REL;
                  hold_cnt_r <= '0;
               end else if (power_btn) begin
                  hold_cnt_r <= sat_inc(hold_cnt_r);
               end else begin
                  hold_cnt_r <= '0;
               end
            end
            ST_ON: begin
               // Long press has priority over the idle timeout.
               if (power_btn && (hold_cnt_r == OFF_MAX)) begin
                  power_on_r  <= 1'b0;
                  off_pulse_r <= 1'b1;
                  state_r     <= ST_WAIT_REL;
                  hold_cnt_r  <= '0;
               end else if (timeout_s) begin
                  // Button is already released, so skip WAIT_REL.
                  power_on_r  <= 1'b0;
                  off_pulse_r <= 1'b1;
                  state_r     <= ST_OFF;
                  hold_cnt_r  <= '0;
               end else if (power_btn) begin
                  hold_cnt_r <= sat_inc(hold_cnt_r);
               end else begin
                  hold_cnt_r <= '0;
               end
            end
            ST_WAIT_REL: begin
               hold_cnt_r <= '0;
               if (!power_btn) begin
                  state_r <= power_on_r ? ST_ON : ST_OFF;
               end else begin
                  state_r <= ST_WAIT_REL;
               end
            end
            default: begin
               state_r    <= ST_OFF;
               hold_cnt_r <= '0;
               power_on_r <= 1'b0;
            end
         endcase
      end
   end

   assign power_on  = power_on_r;
   assign on_pulse  = on_pulse_r;
   assign off_pulse = off_pulse_r;
   assign state     = state_r;

endmodule
